// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants and encodings for the sprite draw engine.
// Package draw_pkg: screen geometry, default sprite parameters, FSM and mode encodings.
package draw_pkg;

  localparam int SCREEN_W        = 320;
  localparam int SCREEN_H        = 240;
  localparam int SPRITE_SIZE_DEF = 4;
  localparam int COLOUR_W_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLOT,
    DONE
  } draw_state_t;

  typedef enum logic {
    MODE_CHAR,
    MODE_BG
  } draw_mode_t;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Request, ROM and VGA signals of the sprite draw engine.
// The host/ROM side uses the master modport; the engine uses the slave modport.
interface sprite_draw_engine_if #(
  parameter int SPRITE_SIZE = draw_pkg::SPRITE_SIZE_DEF,
  parameter int COLOUR_W    = draw_pkg::COLOUR_W_DEF
);
  localparam int AW = $clog2(SPRITE_SIZE * SPRITE_SIZE);

  logic                drawChar;
  logic                drawBG;
  logic [8:0]          xIn;
  logic [7:0]          yIn;
  logic [16:0]         bg_addr;
  logic [COLOUR_W-1:0] bg_data;
  logic [AW-1:0]       spr_addr;
  logic [COLOUR_W-1:0] spr_data;
  logic [8:0]          vga_x;
  logic [7:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                doneChar;
  logic                doneBG;

  modport master (
    output drawChar, drawBG, xIn, yIn, bg_data, spr_data,
    input  bg_addr, spr_addr, vga_x, vga_y, vga_colour, vga_plot, doneChar, doneBG
  );

  modport slave (
    input  drawChar, drawBG, xIn, yIn, bg_data, spr_data,
    output bg_addr, spr_addr, vga_x, vga_y, vga_colour, vga_plot, doneChar, doneBG
  );

endinterface

// File: rtl/sprite_draw_engine_addr_gen.sv
// Combinational pixel coordinate, clip flag and ROM address generation (draw_addr_gen).
// Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
module draw_addr_gen
  import draw_pkg::*;
#(
  parameter  int SPRITE_SIZE = SPRITE_SIZE_DEF,
  localparam int CW          = $clog2(SPRITE_SIZE),
  localparam int AW          = $clog2(SPRITE_SIZE * SPRITE_SIZE)
) (
  input  logic [8:0]    base_x,
  input  logic [7:0]    base_y,
  input  logic [CW-1:0] col,
  input  logic [CW-1:0] row,
  output logic [8:0]    px,
  output logic [7:0]    py,
  output logic          clip,
  output logic [16:0]   bg_addr,
  output logic [AW-1:0] spr_addr
);

  logic [9:0] sum_x;
  logic [8:0] sum_y;

  // NOTE: every output is assigned on every path through always_comb, so no latch can be inferred.
  always_comb begin
    sum_x    = {1'b0, base_x} + 10'(col);
    sum_y    = {1'b0, base_y} + 9'(row);
    clip     = (sum_x >= 10'(SCREEN_W)) || (sum_y >= 9'(SCREEN_H));
    px       = sum_x[8:0];
    py       = sum_y[7:0];
    // y*320 = y*256 + y*64, built from shifts
    bg_addr  = (17'(sum_y) << 8) + (17'(sum_y) << 6) + 17'(sum_x);
    spr_addr = {row, col};
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: plots a character sprite or restores background over a square area.
// Define SPRITE_TRANSPARENCY_EN to skip character pixels whose colour equals TRANSPARENT.
module sprite_draw_engine
  import draw_pkg::*;
#(
  parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int COLOUR_W    = COLOUR_W_DEF,
  parameter int TRANSPARENT = 0
) (
  input logic                 clock,
  input logic                 resetn,
  sprite_draw_engine_if.slave bus
);

  localparam int                CW   = $clog2(SPRITE_SIZE);
  localparam logic [CW-1:0]     LAST = CW'(SPRITE_SIZE - 1);
  localparam logic [COLOUR_W-1:0] KEY = COLOUR_W'(TRANSPARENT);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  draw_state_t   state;
  draw_mode_t    mode;
  logic [8:0]    base_x;
  logic [7:0]    base_y;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          plot_q;
  logic [8:0]    vga_x_q;
  logic [7:0]    vga_y_q;
  logic          done_char_q;
  logic          done_bg_q;

  logic [8:0]    px;
  logic [7:0]    py;
  logic          clip;
  logic          skip;

  draw_addr_gen #(.SPRITE_SIZE(SPRITE_SIZE)) u_addr_gen (
    .base_x   (base_x),
    .base_y   (base_y),
    .col      (col),
    .row      (row),
    .px       (px),
    .py       (py),
    .clip     (clip),
    .bg_addr  (bus.bg_addr),
    .spr_addr (bus.spr_addr)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      mode        <= MODE_CHAR;
      base_x      <= '0;
      base_y      <= '0;
      col         <= '0;
      row         <= '0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      done_char_q <= 1'b0;
      done_bg_q   <= 1'b0;
    end else begin
      done_char_q <= 1'b0;
      done_bg_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.drawBG || bus.drawChar) begin
            mode   <= bus.drawBG ? MODE_BG : MODE_CHAR;
            base_x <= bus.xIn;
            base_y <= bus.yIn;
            col    <= '0;
            row    <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          plot_q  <= !clip;
          vga_x_q <= px;
          vga_y_q <= py;
          state   <= PLOT;
        end
        PLOT: begin
          plot_q <= 1'b0;
          if (col == LAST && row == LAST) begin
            done_bg_q   <= (mode == MODE_BG);
            done_char_q <= (mode == MODE_CHAR);
            state       <= DONE;
          end else begin
            if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            state <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ROM data only becomes valid in the PLOT cycle, so colour and the transparency key bypass the registers.
  assign skip           = KEY_EN && (mode == MODE_CHAR) && (bus.spr_data == KEY);
  assign bus.vga_plot   = (state == PLOT) && plot_q && !skip;
  assign bus.vga_colour = (state != PLOT) ? '0 :
                          (mode == MODE_BG) ? bus.bg_data : bus.spr_data;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.doneChar   = done_char_q;
  assign bus.doneBG     = done_bg_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed self-checking bench for sprite_draw_engine with behavioural background and sprite ROMs.
// Expected plots are rebuilt from the sprite geometry; honours SPRITE_TRANSPARENCY_EN when defined.
module tb_sprite_draw_engine;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] c;
    logic [15:0] cyc;
  } plot_t;

  logic clock;
  logic resetn;

  sprite_draw_engine_if #(.SPRITE_SIZE(4), .COLOUR_W(3)) bus ();

  sprite_draw_engine #(.SPRITE_SIZE(4), .COLOUR_W(3), .TRANSPARENT(0)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int    n_pass;
  int    n_total;
  int    edge_count;
  int    req_edge;
  int    rom_kind;
  plot_t plots[$];
  int    done_bg_n;
  int    done_char_n;
  int    done_bg_cyc;
  int    done_char_cyc;
  int    first_bg_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_count <= edge_count + 1;

  // ROMs: one-cycle read latency
  always @(posedge clock) begin
    bus.bg_data  <= bus.bg_addr[2:0];
    bus.spr_data <= (rom_kind == 1 && !bus.spr_addr[0]) ? 3'd0 : bus.spr_addr[2:0];
  end

  always @(negedge clock) begin
    int mcyc;
    mcyc = edge_count - req_edge + 1;
    if (bus.vga_plot === 1'b1)
      plots.push_back('{16'(bus.vga_x), 16'(bus.vga_y), 16'(bus.vga_colour), 16'(mcyc)});
    if (bus.doneBG === 1'b1) begin
      done_bg_n++;
      done_bg_cyc = mcyc;
    end
    if (bus.doneChar === 1'b1) begin
      done_char_n++;
      done_char_cyc = mcyc;
    end
    if (mcyc == 1) first_bg_addr = int'(bus.bg_addr);
  end

  function automatic int rom_val(input int i);
    if (rom_kind == 1 && (i % 2) == 0) return 0;
    return i % 8;
  endfunction

  // Caller is positioned just after a rising edge; the next edge samples the request.
  task automatic start_req(input bit bg, input bit ch, input int x, input int y);
    plots.delete();
    done_bg_n     = 0;
    done_char_n   = 0;
    done_bg_cyc   = -1;
    done_char_cyc = -1;
    first_bg_addr = -1;
    bus.drawBG    = bg;
    bus.drawChar  = ch;
    bus.xIn       = 9'(x);
    bus.yIn       = 8'(y);
    @(posedge clock);
    #1;
    req_edge     = edge_count;
    bus.drawBG   = 1'b0;
    bus.drawChar = 1'b0;
  endtask

  task automatic check_draw(input bit bg, input int x, input int y, input string name);
    plot_t exp_q[$];
    while (edge_count - req_edge < 44) @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) begin
      int px;
      int py;
      int c;
      px = x + (i % 4);
      py = y + (i / 4);
      if (px >= 320 || py >= 240) continue;
      c = bg ? ((py * 320 + px) % 8) : rom_val(i);
      if (!bg && TRANSP && c == 0) continue;
      exp_q.push_back('{16'(px), 16'(py), 16'(c), 16'(2 + 2 * i)});
    end
    n_total++;
    if (plots.size() !== exp_q.size())
      $display("FAIL %s plot_count got %0d expected %0d", name, plots.size(), exp_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        n_total++;
        if (plots[k] !== exp_q[k])
          $display("FAIL %s plot[%0d] got (%0d,%0d) c=%0d cyc=%0d expected (%0d,%0d) c=%0d cyc=%0d",
                   name, k, plots[k].x, plots[k].y, plots[k].c, plots[k].cyc,
                   exp_q[k].x, exp_q[k].y, exp_q[k].c, exp_q[k].cyc);
        else n_pass++;
      end
    end
    n_total++;
    if ((bg ? done_bg_n : done_char_n) !== 1)
      $display("FAIL %s done_count got %0d expected 1", name, bg ? done_bg_n : done_char_n);
    else n_pass++;
    n_total++;
    if ((bg ? done_bg_cyc : done_char_cyc) !== 33)
      $display("FAIL %s done_cycle got %0d expected 33", name, bg ? done_bg_cyc : done_char_cyc);
    else n_pass++;
    n_total++;
    if ((bg ? done_char_n : done_bg_n) !== 0)
      $display("FAIL %s other_done got %0d expected 0", name, bg ? done_char_n : done_bg_n);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if (bus.vga_plot !== 1'b0) $display("FAIL reset vga_plot got %b expected 0", bus.vga_plot);
    else n_pass++;
    n_total++;
    if (bus.doneChar !== 1'b0) $display("FAIL reset doneChar got %b expected 0", bus.doneChar);
    else n_pass++;
    n_total++;
    if (bus.doneBG !== 1'b0) $display("FAIL reset doneBG got %b expected 0", bus.doneBG);
    else n_pass++;
    n_total++;
    if (bus.vga_x !== 9'd0) $display("FAIL reset vga_x got %0d expected 0", bus.vga_x);
    else n_pass++;
    n_total++;
    if (bus.vga_y !== 8'd0) $display("FAIL reset vga_y got %0d expected 0", bus.vga_y);
    else n_pass++;
    n_total++;
    if (bus.vga_colour !== 3'd0) $display("FAIL reset vga_colour got %0d expected 0", bus.vga_colour);
    else n_pass++;
    n_total++;
    if (bus.bg_addr !== 17'd0) $display("FAIL reset bg_addr got %0d expected 0", bus.bg_addr);
    else n_pass++;
    n_total++;
    if (bus.spr_addr !== 4'd0) $display("FAIL reset spr_addr got %0d expected 0", bus.spr_addr);
    else n_pass++;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    n_total++;
    if (bus.vga_plot !== 1'b0 || bus.doneBG !== 1'b0 || bus.doneChar !== 1'b0)
      $display("FAIL idle_after_reset plot/doneBG/doneChar got %b%b%b expected 000",
               bus.vga_plot, bus.doneBG, bus.doneChar);
    else n_pass++;
  endtask

  task automatic test_bg_draw();
    rom_kind = 0;
    start_req(1'b1, 1'b0, 10, 20);
    check_draw(1'b1, 10, 20, "bg_draw");
    n_total++;
    if (first_bg_addr !== 6410) $display("FAIL bg_draw first_bg_addr got %0d expected 6410", first_bg_addr);
    else n_pass++;
  endtask

  task automatic test_char_draw();
    rom_kind = 0;
    start_req(1'b0, 1'b1, 100, 50);
    check_draw(1'b0, 100, 50, "char_draw");
  endtask

  task automatic test_clip();
    rom_kind = 0;
    start_req(1'b0, 1'b1, 318, 238);
    check_draw(1'b0, 318, 238, "clip");
  endtask

  task automatic test_both_requests();
    rom_kind = 0;
    start_req(1'b1, 1'b1, 40, 60);
    repeat (3) @(posedge clock);
    #1;
    bus.drawChar = 1'b1;
    bus.xIn      = 9'd200;
    bus.yIn      = 8'd100;
    @(posedge clock);
    #1;
    bus.drawChar = 1'b0;
    check_draw(1'b1, 40, 60, "both_requests");
  endtask

  task automatic test_back_to_back();
    rom_kind = 0;
    start_req(1'b1, 1'b0, 0, 0);
    repeat (33) @(posedge clock);
    #1;
    n_total++;
    if (done_bg_n !== 1 || done_bg_cyc !== 33 || plots.size() !== 16)
      $display("FAIL back_to_back first done=%0d cyc=%0d plots=%0d expected 1 33 16",
               done_bg_n, done_bg_cyc, plots.size());
    else n_pass++;
    start_req(1'b0, 1'b1, 200, 100);
    check_draw(1'b0, 200, 100, "back_to_back");
  endtask

  task automatic test_reset_mid();
    rom_kind = 0;
    start_req(1'b1, 1'b0, 0, 0);
    repeat (9) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    while (edge_count - req_edge < 44) @(posedge clock);
    #1;
    n_total++;
    if (plots.size() !== 5) $display("FAIL reset_mid plot_count got %0d expected 5", plots.size());
    else n_pass++;
    n_total++;
    if (plots.size() > 0 && plots[plots.size() - 1].cyc !== 16'd10)
      $display("FAIL reset_mid last_plot_cycle got %0d expected 10", plots[plots.size() - 1].cyc);
    else n_pass++;
    n_total++;
    if (done_bg_n !== 0 || done_char_n !== 0)
      $display("FAIL reset_mid done got bg=%0d char=%0d expected 0 0", done_bg_n, done_char_n);
    else n_pass++;
    @(posedge clock);
    #1;
    start_req(1'b1, 1'b0, 5, 7);
    check_draw(1'b1, 5, 7, "after_reset");
  endtask

  task automatic test_transparency();
    rom_kind = 1;
    start_req(1'b0, 1'b1, 60, 30);
    check_draw(1'b0, 60, 30, "transparency");
    n_total++;
    if (plots.size() !== (TRANSP ? 8 : 16))
      $display("FAIL transparency plots got %0d expected %0d", plots.size(), TRANSP ? 8 : 16);
    else n_pass++;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    edge_count   = 0;
    req_edge     = 0;
    rom_kind     = 0;
    resetn       = 1'b0;
    bus.drawBG   = 1'b0;
    bus.drawChar = 1'b0;
    bus.xIn      = '0;
    bus.yIn      = '0;
    test_reset();
    test_bg_draw();
    test_char_draw();
    test_clip();
    test_both_requests();
    test_back_to_back();
    test_reset_mid();
    test_transparency();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
